// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd core, its operand sequencer and the benches:
// default parameters, sequencer state encodings and a small width helper.
package gcd_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_CLR_CYCLES = 3;
  localparam int DEF_TIMEOUT    = 64;

  // Sequencer state encodings.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_ARM   = ST_ARM,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } seq_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_seq_if.sv
// Operand and result valid/ready streams of the gcd sequencer.
// master = the party issuing operands and taking results; slave = gcd_seq.
interface gcd_seq_if #(
  parameter int WIDTH = gcd_pkg::DEF_WIDTH
);

  // Operand stream.
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // Result stream.
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  modport master (
    output op_valid, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  op_valid, op_a, op_b, res_ready,
    output op_ready, res_valid, res_data, res_err
  );

endinterface

// File: rtl/gcd_wdog.sv
// Clearable, saturating cycle counter used as the WAIT-state watchdog.
// expired is high during the cycle whose count brings the total to TIMEOUT,
// so the owner can react on the edge that ends the TIMEOUT-th counted cycle.
module gcd_wdog
  import gcd_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int             CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0]  LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  assign expired = en && (count >= LAST);

  // Count enabled cycles, zero on clr, stick at LIMIT instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/gcd_seq.sv
// Operand sequencer / result collector in front of the gcd core.
// Accepts an operand pair, clears and arms the core, waits for done (or a
// watchdog timeout) and returns the result over the result stream.
// Zero operands bypass the core entirely: gcd(0,x) = x = 0|x.
module gcd_seq
  import gcd_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  gcd_seq_if.slave         ctl,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic             core_clr_n,
  input  logic [WIDTH-1:0] core_out,
  input  logic             core_done,
  output logic             busy
);

  localparam int            CW       = cnt_width(CLR_CYCLES);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

  seq_state_e    state;
  logic [CW-1:0] clr_cnt;
  logic          wdog_clr;
  logic          wdog_en;
  logic          wdog_expired;

  // Only the two handshake qualifiers decode state; everything else is a register.
  assign ctl.op_ready = (state == S_IDLE);
  assign busy         = (state != S_IDLE);

  // Watchdog is zeroed during the ARM settle cycle and runs only in WAIT.
  assign wdog_clr = (state == S_ARM);
  assign wdog_en  = (state == S_WAIT);

  gcd_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  // Sequencer FSM with registered core-control and result outputs.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking assignments would make later lines see new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand/result registers are reset too, not just the state,
      // because their reset values are visible on ports and an aborted
      // operation must leave nothing behind.
      state         <= S_IDLE;
      clr_cnt       <= '0;
      core_a        <= '0;
      core_b        <= '0;
      core_clr_n    <= 1'b0;
      ctl.res_valid <= 1'b0;
      ctl.res_data  <= '0;
      ctl.res_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctl.op_valid) begin
            core_a <= ctl.op_a;
            core_b <= ctl.op_b;
            if ((ctl.op_a == '0) || (ctl.op_b == '0)) begin
              ctl.res_data  <= ctl.op_a | ctl.op_b;
              ctl.res_err   <= 1'b0;
              ctl.res_valid <= 1'b1;
              state         <= S_RESP;
            end else begin
              clr_cnt <= '0;
              state   <= S_CLEAR;
            end
          end
        end

        S_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            core_clr_n <= 1'b1;
            state      <= S_ARM;
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
          end
        end

        // One settle cycle after releasing clear; core_done is not looked at.
        S_ARM: begin
          state <= S_WAIT;
        end

        // core_done is tested first so it wins over a same-cycle expiry.
        S_WAIT: begin
          if (core_done) begin
            ctl.res_data  <= core_out;
            ctl.res_err   <= 1'b0;
            ctl.res_valid <= 1'b1;
            core_clr_n    <= 1'b0;
            state         <= S_RESP;
          end else if (wdog_expired) begin
            ctl.res_data  <= '0;
            ctl.res_err   <= 1'b1;
            ctl.res_valid <= 1'b1;
            core_clr_n    <= 1'b0;
            state         <= S_RESP;
          end
        end

        S_RESP: begin
          if (ctl.res_ready) begin
            ctl.res_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end

        default: begin
          core_clr_n    <= 1'b0;
          ctl.res_valid <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_seq.sv
// Self-checking bench for gcd_seq. A behavioural gcd core with programmable
// done latency (0 = never done) sits behind the sequencer; expected results
// and cycle counts are derived from Euclid's algorithm and the protocol timing.
module tb_gcd_seq;
  import gcd_pkg::*;

  localparam int W  = 8;
  localparam int C  = 3;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] core_a, core_b, core_out;
  logic         core_clr_n, core_done, busy;

  int checks = 0;
  int errors = 0;
  int core_lat;
  int core_cnt;

  always #5 clk = ~clk;

  gcd_seq_if #(.WIDTH(W)) io ();

  gcd_seq #(
    .WIDTH      (W),
    .CLR_CYCLES (C),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctl        (io.slave),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_clr_n (core_clr_n),
    .core_out   (core_out),
    .core_done  (core_done),
    .busy       (busy)
  );

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // Behavioural core: counts cycles out of clear and raises done at core_lat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !core_clr_n) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
      core_out  <= '0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_lat != 0 && core_cnt + 1 == core_lat) begin
        core_done <= 1'b1;
        core_out  <= ref_gcd(core_a, core_b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation: issue at a negedge, track the core-clear profile and
  // latency, check the result, optionally stall res_ready for hold cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input bit early, input int hold);
    logic [W-1:0] exp_data;
    logic         exp_err;
    int           exp_k;
    int           k      = 0;
    int           rise_k = -1;
    int           hi_cnt = 0;
    bit           rdy_seen = 1'b0;
    bit           idle_seen = 1'b0;
    bit           bypass = (a == '0) || (b == '0);

    if (bypass) begin
      exp_data = a | b;  exp_err = 1'b0; exp_k = 0;
    end else if (lat >= 1 && lat <= TO) begin
      exp_data = ref_gcd(a, b); exp_err = 1'b0; exp_k = C + 1 + lat;
    end else begin
      exp_data = '0; exp_err = 1'b1; exp_k = C + 1 + TO;
    end

    core_lat = lat;
    check("op_ready_idle", 32'(io.op_ready), 1);
    io.op_a = a; io.op_b = b; io.op_valid = 1'b1; io.res_ready = early;
    @(posedge clk);
    @(negedge clk);
    io.op_valid = 1'b0;
    check("core_a_latched", 32'(core_a), 32'(a));
    check("core_b_latched", 32'(core_b), 32'(b));

    while (!io.res_valid && k < C + TO + 8) begin
      if (io.op_ready) rdy_seen = 1'b1;
      if (!busy)       idle_seen = 1'b1;
      if (core_clr_n) begin
        hi_cnt++;
        if (rise_k < 0) rise_k = k;
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end

    check("latency", 32'(k), 32'(exp_k));
    check("res_data", 32'(io.res_data), 32'(exp_data));
    check("res_err", 32'(io.res_err), 32'(exp_err));
    check("op_ready_during_op", 32'(rdy_seen), 0);
    check("busy_during_op", 32'(idle_seen), 0);
    check("resp_clr_n", 32'(core_clr_n), 0);
    if (!bypass) begin
      check("clr_release_edge", 32'(rise_k), 32'(C));
      check("clr_high_cycles", 32'(hi_cnt), 32'(exp_k - C));
    end

    if (!early) begin
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_valid", 32'(io.res_valid), 1);
        check("hold_data", 32'(io.res_data), 32'(exp_data));
        check("hold_err", 32'(io.res_err), 32'(exp_err));
        check("hold_clr_n", 32'(core_clr_n), 0);
        check("hold_op_ready", 32'(io.op_ready), 0);
      end
      io.res_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("res_valid_drop", 32'(io.res_valid), 0);
    check("op_ready_back", 32'(io.op_ready), 1);
    io.res_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           rl;
    bit           stray;

    rst_n = 1'b0;
    io.op_valid = 1'b0; io.op_a = '0; io.op_b = '0; io.res_ready = 1'b0;
    core_lat = 5;
    #1;
    check("rst_op_ready", 32'(io.op_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_clr_n", 32'(core_clr_n), 0);
    check("rst_res_valid", 32'(io.res_valid), 0);
    check("rst_res_data", 32'(io.res_data), 0);
    check("rst_core_a", 32'(core_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(8'd70,  8'd140, 6,  1'b1, 0);
    run_op(8'd18,  8'd170, 4,  1'b0, 0);
    run_op(8'd180, 8'd160, 9,  1'b0, 0);
    run_op(8'd0,   8'd45,  5,  1'b0, 0);
    run_op(8'd0,   8'd0,   5,  1'b0, 0);
    run_op(8'd45,  8'd0,   5,  1'b1, 0);
    run_op(8'd91,  8'd65,  0,  1'b0, 0);   // done stuck low -> timeout
    run_op(8'd91,  8'd65,  64, 1'b0, 0);   // done on the last WAIT cycle
    run_op(8'd91,  8'd65,  65, 1'b0, 0);   // one cycle too late -> timeout
    run_op(8'd12,  8'd18,  1,  1'b0, 10);  // stalled result consumer

    // Reset in the middle of WAIT.
    core_lat = 10;
    io.op_a = 8'd70; io.op_b = 8'd140; io.op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.op_valid = 1'b0;
    repeat (C + 3) @(posedge clk);
    #2;
    check("pre_rst_clr_n", 32'(core_clr_n), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_clr_n", 32'(core_clr_n), 0);
    check("mid_rst_core_a", 32'(core_a), 0);
    check("mid_rst_core_b", 32'(core_b), 0);
    check("mid_rst_res_valid", 32'(io.res_valid), 0);
    check("mid_rst_res_data", 32'(io.res_data), 0);
    check("mid_rst_res_err", 32'(io.res_err), 0);
    check("mid_rst_op_ready", 32'(io.op_ready), 1);
    check("mid_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (io.res_valid || busy) stray = 1'b1;
    end
    check("no_stray_after_rst", 32'(stray), 0);
    run_op(8'd70, 8'd140, 6, 1'b0, 0);

    // Randomized operations.
    for (int i = 0; i < 16; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      case ($urandom_range(0, 5))
        0:       rl = 0;
        1:       rl = 64;
        2:       rl = 65;
        default: rl = $urandom_range(1, 30);
      endcase
      run_op(ra, rb, rl, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_seq.md
# gcd_seq

Operand sequencer and result collector that sits in front of the `gcd` core and acts as its initiator. It accepts operand pairs over a valid/ready stream and drives them into the core. It restarts the core by pulsing the core's active-low clear, waits for `done`, and returns the result (or a timeout error) over a second valid/ready stream. It replaces the manual clear/load sequencing that the gate-level bench performs by hand.

## Interface
- `WIDTH`, 8: operand and result width.
- `CLR_CYCLES`, 3: cycles the core is held in clear before each operation (≥1).
- `TIMEOUT`, 64: maximum WAIT cycles before an error result (≥2).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op_valid` in 1, `op_ready` out 1, `op_a` in WIDTH, `op_b` in WIDTH: operand stream.
- `core_a` out WIDTH, `core_b` out WIDTH: registered operands to the core's `A_in`/`B_in`.
- `core_clr_n` out 1: drives the core's `rst_n`. 0 holds the core cleared.
- `core_out` in WIDTH, `core_done` in 1: core result and completion flag.
- `res_valid` out 1, `res_ready` in 1, `res_data` out WIDTH, `res_err` out 1: result stream.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, ARM, WAIT, RESP. Encoded as 3-bit localparams.
- **IDLE**
  - `op_ready`=1 in this state only.
  - On `op_valid`&&`op_ready`, latch `op_a`/`op_b` into `core_a`/`core_b`.
  - If either operand is 0, bypass the core: `res_data` = `op_a|op_b`, giving gcd(0,x)=x and gcd(0,0)=0. Set `res_err`=0 and go to RESP.
  - Otherwise go to CLEAR.
- **CLEAR**: `core_clr_n`=0 for exactly `CLR_CYCLES` cycles, then go to ARM.
- **ARM**: `core_clr_n`=1. This is a one-cycle settle, and `core_done` is ignored. Next state is WAIT; the watchdog is zeroed.
- **WAIT**
  - `core_clr_n`=1 and the watchdog increments each cycle.
  - If `core_done`=1: capture `core_out` into `res_data`, set `res_err`=0, go to RESP.
  - Else if the watchdog reaches `TIMEOUT`: set `res_data`=0, `res_err`=1, go to RESP.
  - If `core_done` rises on the same cycle the count expires, `core_done` wins.
- **RESP**
  - `res_valid`=1, `core_clr_n`=0 (core parked).
  - `res_data`/`res_err` hold stable until `res_valid`&&`res_ready`, then go to IDLE.
- `core_clr_n`=1 only in ARM and WAIT. In all other states the core is held cleared.
- `core_a`/`core_b` change only on acceptance.
- Watchdog width is $clog2(TIMEOUT+1) and it saturates, never wraps.
- Reset mid-operation: everything returns to IDLE asynchronously and the in-flight operand pair is dropped. No result is produced.

## Timing
- Reset values:
  - state IDLE
  - `op_ready`=1, `busy`=0
  - `core_a`=`core_b`=0, `core_clr_n`=0
  - `res_valid`=0, `res_data`=0, `res_err`=0
  - watchdog 0
- All outputs are registered except `op_ready` and `busy`, which decode state.
- For an acceptance at edge T:
  - `core_clr_n` is low for edges T+1..T+CLR_CYCLES.
  - ARM occupies cycle T+CLR_CYCLES+1.
  - `core_done` is first sampled at T+CLR_CYCLES+2.
- `core_done` sampled high at edge D gives `res_valid`=1 from D+1.
- Bypass result: `res_valid`=1 one cycle after acceptance.
- Timeout result: `res_valid`=1 after `TIMEOUT` WAIT cycles.
- Throughput is one operation in flight. `op_ready` returns 1 the cycle after the RESP handshake.

## Structure
- `gcd_pkg`: state encodings, default `WIDTH`/`CLR_CYCLES`/`TIMEOUT`. Shared with the `gcd` core and the benches.
- One sub-module is natural: `gcd_wdog`, a clearable saturating cycle counter with an `expired` flag. Instantiate it once.
- The FSM, operand registers and result registers live in `gcd_seq`.

## Test plan
- (70,140), `res_ready`=1, RTL or SDF-annotated `gcd` → `res_data`=70, `res_err`=0; `core_clr_n` low exactly 3 cycles.
- Back-to-back (18,170) then (180,160) → results 2 then 20 in order. `op_ready`=0 throughout each operation.
- (0,45) → `res_data`=45 one cycle after acceptance; `core_clr_n` never released. (0,0) → 0.
- Core model with `done` stuck at 0 → after 64 WAIT cycles, `res_err`=1 and `res_data`=0. `done` arriving on the 64th WAIT cycle → valid result, `res_err`=0.
- `res_ready` held low 10 cycles in RESP → `res_valid`/`res_data` stable, `core_clr_n`=0, `op_ready`=0; released → IDLE next cycle.
- `rst_n` asserted mid-WAIT → all outputs at reset values immediately. No stray `res_valid` after release; the next op (70,140) → 70.
